// File: rtl/mem_stage.sv
// mem_stage: in-order memory stage between execute and writeback.
// Queues ALU results, runs loads/stores on the dmem bus, hands results to writeback.
module mem_stage #(
    parameter int QUEUE_DEPTH = 2,
    parameter int REG_IDX_W   = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 exe_mem,
    input  logic [127:0]         result,
    input  logic [63:0]          rflags,
    input  logic [1:0]           ex_mem_op,
    input  logic [63:0]          ex_store_data,
    input  logic [REG_IDX_W-1:0] ex_dest,
    output logic                 mem_blocked,
    output logic                 dmem_req,
    output logic                 dmem_we,
    output logic [63:0]          dmem_addr,
    output logic [63:0]          dmem_wdata,
    input  logic                 dmem_ack,
    input  logic [63:0]          dmem_rdata,
    output logic                 wb_valid,
    output logic [127:0]         wb_data,
    output logic [63:0]          wb_rflags,
    output logic [REG_IDX_W-1:0] wb_dest,
    input  logic                 wb_ready
);
    localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int CW = $clog2(QUEUE_DEPTH + 1);
    localparam logic [1:0] OP_LOAD  = 2'b01;
    localparam logic [1:0] OP_STORE = 2'b10;

    typedef struct packed {
        logic [127:0]         result;
        logic [63:0]          rflags;
        logic [1:0]           op;
        logic [63:0]          sdata;
        logic [REG_IDX_W-1:0] dest;
    } entry_t;

    typedef enum logic [1:0] {IDLE, MEM_WAIT, WB_STALL} state_t;

    entry_t               fifo_q [QUEUE_DEPTH];
    entry_t               new_entry;
    entry_t               head;
    logic [PW-1:0]        head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic [CW:0]          count_nxt;
    state_t               state_q, state_d;
    logic                 req_q, req_d, we_q, we_d;
    logic [63:0]          addr_q, addr_d, wdata_q, wdata_d;
    logic [63:0]          hold_q, hold_d;
    logic                 wb_valid_q, wb_valid_d;
    logic [127:0]         wb_data_q, wb_data_d, out_data;
    logic [63:0]          wb_rflags_q, wb_rflags_d;
    logic [REG_IDX_W-1:0] wb_dest_q, wb_dest_d;
    logic                 enq, deq, out_free, out_load, head_mem;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(QUEUE_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        new_entry.result = result;
        new_entry.rflags = rflags;
        new_entry.op     = ex_mem_op;
        new_entry.sdata  = ex_store_data;
        new_entry.dest   = ex_dest;
        head     = fifo_q[head_q];
        head_mem = (head.op == OP_LOAD) || (head.op == OP_STORE);
        out_free = !wb_valid_q || wb_ready;
    end

    always_comb begin
        state_d  = state_q;
        deq      = 1'b0;
        out_load = 1'b0;
        out_data = head.result;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        hold_d   = hold_q;
        unique case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    if (head_mem) begin
                        req_d   = 1'b1;
                        we_d    = (head.op == OP_STORE);
                        addr_d  = head.result[63:0];
                        wdata_d = head.sdata;
                        state_d = MEM_WAIT;
                    end else if (out_free) begin
                        out_load = 1'b1;
                        deq      = 1'b1;
                    end
                end
            end
            MEM_WAIT: begin
                if (head.op == OP_LOAD) out_data = {64'b0, dmem_rdata};
                if (dmem_ack) begin
                    req_d = 1'b0;
                    if (out_free) begin
                        out_load = 1'b1;
                        deq      = 1'b1;
                        state_d  = IDLE;
                    end else begin
                        hold_d  = dmem_rdata;
                        state_d = WB_STALL;
                    end
                end
            end
            WB_STALL: begin
                if (head.op == OP_LOAD) out_data = {64'b0, hold_q};
                if (out_free) begin
                    out_load = 1'b1;
                    deq      = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A full queue only accepts a new entry when the head leaves in the same cycle.
    always_comb begin
        enq       = exe_mem && ((count_q != CW'(QUEUE_DEPTH)) || deq);
        count_d   = count_q + CW'(enq) - CW'(deq);
        tail_d    = enq ? ptr_inc(tail_q) : tail_q;
        head_d    = deq ? ptr_inc(head_q) : head_q;
        count_nxt = {1'b0, count_q} + (CW+1)'(exe_mem) - (CW+1)'(deq);
        mem_blocked = (count_nxt >= (CW+1)'(QUEUE_DEPTH));
    end

    always_comb begin
        wb_valid_d  = wb_valid_q && !wb_ready;
        wb_data_d   = wb_data_q;
        wb_rflags_d = wb_rflags_q;
        wb_dest_d   = wb_dest_q;
        if (out_load) begin
            wb_valid_d  = 1'b1;
            wb_data_d   = out_data;
            wb_rflags_d = head.rflags;
            wb_dest_d   = head.dest;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && enq) fifo_q[tail_q] <= new_entry;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            req_q       <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            hold_q      <= '0;
            wb_valid_q  <= 1'b0;
            wb_data_q   <= '0;
            wb_rflags_q <= '0;
            wb_dest_q   <= '0;
        end else begin
            state_q     <= state_d;
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            req_q       <= req_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            hold_q      <= hold_d;
            wb_valid_q  <= wb_valid_d;
            wb_data_q   <= wb_data_d;
            wb_rflags_q <= wb_rflags_d;
            wb_dest_q   <= wb_dest_d;
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign wb_valid   = wb_valid_q;
    assign wb_data    = wb_data_q;
    assign wb_rflags  = wb_rflags_q;
    assign wb_dest    = wb_dest_q;
endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed latency cases plus random ALU/memory traffic
// compared against a transaction-level model of the memory stage.
module tb_mem_stage;
    logic         clk;
    logic         reset_n;
    logic         exe_mem;
    logic [127:0] result;
    logic [63:0]  rflags;
    logic [1:0]   ex_mem_op;
    logic [63:0]  ex_store_data;
    logic [3:0]   ex_dest;
    logic         mem_blocked;
    logic         dmem_req;
    logic         dmem_we;
    logic [63:0]  dmem_addr;
    logic [63:0]  dmem_wdata;
    logic         dmem_ack;
    logic [63:0]  dmem_rdata;
    logic         wb_valid;
    logic [127:0] wb_data;
    logic [63:0]  wb_rflags;
    logic [3:0]   wb_dest;
    logic         wb_ready;

    mem_stage #(.QUEUE_DEPTH(2), .REG_IDX_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .exe_mem(exe_mem), .result(result),
        .rflags(rflags), .ex_mem_op(ex_mem_op), .ex_store_data(ex_store_data),
        .ex_dest(ex_dest), .mem_blocked(mem_blocked), .dmem_req(dmem_req),
        .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata), .wb_valid(wb_valid),
        .wb_data(wb_data), .wb_rflags(wb_rflags), .wb_dest(wb_dest),
        .wb_ready(wb_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [63:0]  flags;
        logic [3:0]   dest;
    } wb_t;

    typedef struct {
        logic        we;
        logic [63:0] addr;
        logic [63:0] wdata;
    } req_t;

    wb_t         wb_exp[$];
    req_t        mem_exp[$];
    logic [63:0] ref_mem [logic [63:0]];
    logic [63:0] bus_mem [logic [63:0]];
    req_t        cur;
    int          errors;
    int          checks;
    int          wait_cnt;
    int          ack_delay;
    bit          rand_delay;
    logic        in_req;
    logic        ack_next;
    logic [63:0] rdata_next;
    logic        blk_seen;

    function automatic logic [63:0] dflt(input logic [63:0] a);
        return a ^ 64'h5A5A_0000_C3C3_0000;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [1:0] op, input logic [127:0] res,
                         input logic [63:0] sd, input logic [63:0] fl,
                         input logic [3:0] dst);
        exe_mem       = 1'b1;
        ex_mem_op     = op;
        result        = res;
        ex_store_data = sd;
        rflags        = fl;
        ex_dest       = dst;
    endtask

    // Monitor/model at negedge, memory responder drives just after posedge.
    task automatic tick();
        wb_t         e;
        wb_t         w;
        req_t        r;
        logic [63:0] a;
        @(negedge clk);
        ack_next = 1'b0;
        if (!reset_n) begin
            wb_exp.delete();
            mem_exp.delete();
            in_req   = 1'b0;
            blk_seen = 1'b0;
        end else begin
            if (wb_valid && wb_ready) begin
                if (wb_exp.size() == 0) begin
                    chk("wb_extra", 128'(wb_valid), 128'(0));
                end else begin
                    e = wb_exp.pop_front();
                    chk("wb_data", wb_data, e.data);
                    chk("wb_rflags", 128'(wb_rflags), 128'(e.flags));
                    chk("wb_dest", 128'(wb_dest), 128'(e.dest));
                end
            end
            if (dmem_req && !in_req) begin
                if (mem_exp.size() == 0) begin
                    chk("req_extra", 128'(dmem_req), 128'(0));
                end else begin
                    cur      = mem_exp.pop_front();
                    in_req   = 1'b1;
                    wait_cnt = rand_delay ? int'($urandom_range(0, 3)) : ack_delay - 1;
                end
            end
            if (in_req) begin
                chk("req_held", 128'(dmem_req), 128'(1));
                chk("req_we", 128'(dmem_we), 128'(cur.we));
                chk("req_addr", 128'(dmem_addr), 128'(cur.addr));
                chk("req_wdata", 128'(dmem_wdata), 128'(cur.wdata));
                if (dmem_ack) begin
                    if (cur.we) bus_mem[cur.addr] = cur.wdata;
                    in_req = 1'b0;
                end else if (wait_cnt == 0) begin
                    ack_next   = 1'b1;
                    rdata_next = bus_mem.exists(cur.addr) ? bus_mem[cur.addr]
                                                          : dflt(cur.addr);
                end else begin
                    wait_cnt--;
                end
            end
            if (exe_mem) begin
                a       = result[63:0];
                w.data  = result;
                w.flags = rflags;
                w.dest  = ex_dest;
                if (ex_mem_op == 2'b01) begin
                    r = '{1'b0, a, ex_store_data};
                    mem_exp.push_back(r);
                    w.data = {64'b0, ref_mem.exists(a) ? ref_mem[a] : dflt(a)};
                end else if (ex_mem_op == 2'b10) begin
                    r = '{1'b1, a, ex_store_data};
                    mem_exp.push_back(r);
                    ref_mem[a] = ex_store_data;
                end
                wb_exp.push_back(w);
            end
            blk_seen = mem_blocked;
        end
        @(posedge clk);
        #1;
        dmem_ack   = ack_next;
        dmem_rdata = ack_next ? rdata_next : {$urandom, $urandom};
    endtask

    initial begin
        errors = 0; checks = 0; wait_cnt = 0; ack_delay = 1; rand_delay = 0;
        in_req = 0; ack_next = 0; rdata_next = '0; blk_seen = 0;
        reset_n = 0; exe_mem = 0; result = '0; rflags = '0; ex_mem_op = '0;
        ex_store_data = '0; ex_dest = '0; dmem_ack = 0; dmem_rdata = '0;
        wb_ready = 1;
        ref_mem[64'h1000] = 64'hDEAD_BEEF;
        bus_mem[64'h1000] = 64'hDEAD_BEEF;
        tick();
        tick();
        chk("rst_req", 128'(dmem_req), 128'(0));
        chk("rst_we", 128'(dmem_we), 128'(0));
        chk("rst_addr", 128'(dmem_addr), 128'(0));
        chk("rst_wdata", 128'(dmem_wdata), 128'(0));
        chk("rst_wb_valid", 128'(wb_valid), 128'(0));
        chk("rst_wb_data", wb_data, 128'(0));
        chk("rst_wb_rflags", 128'(wb_rflags), 128'(0));
        chk("rst_wb_dest", 128'(wb_dest), 128'(0));
        chk("rst_blocked", 128'(mem_blocked), 128'(0));
        reset_n = 1;
        tick();

        // ALU op: wb_valid two cycles after exe_mem
        issue(2'b00, 128'h1234, 64'h0, 64'hF00D, 4'h9);
        tick();
        exe_mem = 0;
        chk("t1_early", 128'(wb_valid), 128'(0));
        tick();
        chk("t1_valid", 128'(wb_valid), 128'(1));
        chk("t1_data", wb_data, 128'h1234);
        chk("t1_rflags", 128'(wb_rflags), 128'hF00D);
        chk("t1_dest", 128'(wb_dest), 128'h9);
        chk("t1_noreq", 128'(dmem_req), 128'(0));
        tick();
        tick();

        // Load with ack three cycles after request
        ack_delay = 3;
        issue(2'b01, 128'h1000, 64'h0, 64'h1, 4'h3);
        tick();
        exe_mem = 0;
        tick();
        chk("t2_req", 128'(dmem_req), 128'(1));
        chk("t2_we", 128'(dmem_we), 128'(0));
        chk("t2_addr", 128'(dmem_addr), 128'h1000);
        tick();
        tick();
        tick();
        chk("t2_req_at_ack", 128'(dmem_req), 128'(1));
        tick();
        chk("t2_valid", 128'(wb_valid), 128'(1));
        chk("t2_data", wb_data, 128'hDEAD_BEEF);
        chk("t2_req_drop", 128'(dmem_req), 128'(0));
        tick();
        tick();

        // Store
        ack_delay = 1;
        issue(2'b10, {64'hABCD, 64'h2000}, 64'h55, 64'h2, 4'h4);
        tick();
        exe_mem = 0;
        tick();
        chk("t3_we", 128'(dmem_we), 128'(1));
        chk("t3_wdata", 128'(dmem_wdata), 128'h55);
        chk("t3_addr", 128'(dmem_addr), 128'h2000);
        tick();
        tick();
        chk("t3_valid", 128'(wb_valid), 128'(1));
        chk("t3_data", wb_data, {64'hABCD, 64'h2000});
        tick();
        tick();

        // Back-pressure with a stalled writeback
        wb_ready = 0;
        issue(2'b00, 128'hA1, 64'h0, 64'h11, 4'h1);
        tick();
        issue(2'b00, 128'hB2, 64'h0, 64'h22, 4'h2);
        #1;
        chk("t4_blk_lo", 128'(mem_blocked), 128'(0));
        tick();
        issue(2'b00, 128'hC3, 64'h0, 64'h33, 4'h3);
        #1;
        chk("t4_blk_hi", 128'(mem_blocked), 128'(1));
        tick();
        exe_mem = 0;
        #1;
        chk("t4_blk_hold", 128'(mem_blocked), 128'(1));
        chk("t4_head_out", wb_data, 128'hA1);
        tick();
        tick();
        wb_ready = 1;
        for (int i = 0; i < 8; i++) tick();
        chk("t4_blk_clear", 128'(mem_blocked), 128'(0));

        // Load acked while writeback is stalled
        wb_ready = 0;
        issue(2'b00, 128'h77, 64'h0, 64'h44, 4'h5);
        tick();
        issue(2'b01, 128'h3000, 64'h0, 64'h45, 4'h6);
        tick();
        exe_mem = 0;
        tick();
        chk("t5_req", 128'(dmem_req), 128'(1));
        tick();
        tick();
        chk("t5_req_drop", 128'(dmem_req), 128'(0));
        chk("t5_prior", wb_data, 128'h77);
        tick();
        chk("t5_prior_stable", wb_data, 128'h77);
        wb_ready = 1;
        tick();
        chk("t5_ld_valid", 128'(wb_valid), 128'(1));
        chk("t5_ld_data", wb_data, {64'b0, dflt(64'h3000)});
        tick();
        tick();

        // Reset during an outstanding load, then a stray ack
        ack_delay = 10;
        issue(2'b01, 128'h4000, 64'h0, 64'h46, 4'h7);
        tick();
        exe_mem = 0;
        tick();
        tick();
        chk("t6_req", 128'(dmem_req), 128'(1));
        reset_n = 0;
        tick();
        chk("t6_req_rst", 128'(dmem_req), 128'(0));
        chk("t6_valid_rst", 128'(wb_valid), 128'(0));
        chk("t6_blk_rst", 128'(mem_blocked), 128'(0));
        chk("t6_addr_rst", 128'(dmem_addr), 128'(0));
        reset_n = 1;
        tick();
        dmem_ack   = 1;
        dmem_rdata = 64'h1111;
        tick();
        chk("t6_stray_valid", 128'(wb_valid), 128'(0));
        chk("t6_stray_req", 128'(dmem_req), 128'(0));
        tick();
        chk("t6_stray_valid2", 128'(wb_valid), 128'(0));

        // Random traffic against the model
        rand_delay = 1;
        for (int c = 0; c < 600; c++) begin
            wb_ready = ($urandom_range(0, 3) != 0);
            if (!blk_seen && ($urandom_range(0, 2) != 0))
                issue(2'($urandom_range(0, 3)),
                      {$urandom, $urandom, 60'h800, 4'($urandom_range(0, 15))},
                      {$urandom, $urandom}, {$urandom, $urandom},
                      4'($urandom));
            else
                exe_mem = 0;
            tick();
        end
        exe_mem  = 0;
        wb_ready = 1;
        for (int i = 0; i < 200 && (wb_exp.size() != 0); i++) tick();
        chk("drain_wb", 128'(wb_exp.size()), 128'(0));
        chk("drain_mem", 128'(mem_exp.size()), 128'(0));
        chk("drain_req", 128'(dmem_req), 128'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
